// File: rtl/cpu7_ifu_imd_pipe_pkg.sv
// Decode-result layout, immediate-shift/ALU codes and instruction field helpers shared by the
// D->E immediate pipe and its per-lane decoder.
package cpu7_ifu_imd_pipe_pkg;

  localparam int unsigned DecodeResBit = 15;

  localparam int unsigned OpI5      = 0;
  localparam int unsigned OpI12     = 1;
  localparam int unsigned OpI14     = 2;
  localparam int unsigned OpI16     = 3;
  localparam int unsigned OpI20     = 4;
  localparam int unsigned OpUnsign  = 5;
  localparam int unsigned OpDw      = 6;
  localparam int unsigned OpSa      = 7;
  localparam int unsigned OpShiftLo = 8;   // 3-bit imm_shift_e
  localparam int unsigned OpAluLo   = 11;  // 4-bit alu_op_e

  typedef enum logic [2:0] {
    ShiftNone = 3'd0,
    Shift2    = 3'd1,
    Shift12   = 3'd2,
    Shift16   = 3'd3,
    Shift18   = 3'd4
  } imm_shift_e;

  typedef enum logic [3:0] {
    AluAdd    = 4'd0,
    AluCountL = 4'd1,
    AluCountT = 4'd2,
    AluAlign  = 4'd3,
    AluExt    = 4'd4,
    AluIns    = 4'd5
  } alu_op_e;

  function automatic logic [2:0] get_sa(input logic [31:0] inst);
    return inst[17:15];
  endfunction

  function automatic logic [11:0] get_mslsbd(input logic [31:0] inst);
    return inst[21:10];
  endfunction

endpackage

// File: rtl/cpu7_ifu_imd_lane.sv
// Combinational per-lane immediate decode: shifted immediate, ALU auxiliary constant and
// PC-relative branch target, all at GRLEN.
module cpu7_ifu_imd_lane
  import cpu7_ifu_imd_pipe_pkg::*;
#(
  parameter int unsigned GRLEN = 32
) (
  input  logic [31:0]             i_inst,
  input  logic [DecodeResBit-1:0] i_op,
  input  logic [GRLEN-1:0]        i_pc,
  output logic [GRLEN-1:0]        o_imm_shifted,
  output logic [GRLEN-1:0]        o_c,
  output logic [GRLEN-1:0]        o_br_target
);

  imm_shift_e       w_shift;
  alu_op_e          w_alu;
  logic [GRLEN-1:0] w_imm;
  logic [31:0]      w_sh32;
  logic             w_unused_inst;

  assign w_shift       = imm_shift_e'(i_op[OpShiftLo +: 3]);
  assign w_alu         = alu_op_e'(i_op[OpAluLo +: 4]);
  assign w_unused_inst = ^{i_inst[31:26], i_inst[4:0]};

  always_comb begin
    w_imm = '0;
    if (i_op[OpI5]) begin
      w_imm = i_op[OpDw] ? GRLEN'(i_inst[15:10]) : GRLEN'(i_inst[14:10]);
    end else if (i_op[OpI12]) begin
      w_imm = i_op[OpUnsign] ? GRLEN'(i_inst[21:10]) : GRLEN'($signed(i_inst[21:10]));
    end else if (i_op[OpI14]) begin
      w_imm = GRLEN'($signed(i_inst[23:10]));
    end else if (i_op[OpI16]) begin
      w_imm = GRLEN'($signed(i_inst[25:10]));
    end else if (i_op[OpI20]) begin
      w_imm = GRLEN'($signed(i_inst[24:5]));
    end
  end

  // Large shifts operate on a 32-bit word and re-extend from bit 31, matching the 32-bit ISA.
  always_comb begin
    w_sh32        = '0;
    o_imm_shifted = w_imm;
    case (w_shift)
      Shift2:  o_imm_shifted = w_imm << 2;
      Shift12: begin
        w_sh32        = {w_imm[19:0], 12'b0};
        o_imm_shifted = GRLEN'($signed(w_sh32));
      end
      Shift16: begin
        w_sh32        = {w_imm[15:0], 16'b0};
        o_imm_shifted = GRLEN'($signed(w_sh32));
      end
      Shift18: begin
        w_sh32        = {w_imm[13:0], 18'b0};
        o_imm_shifted = GRLEN'($signed(w_sh32));
      end
      default: ;
    endcase
  end

  always_comb begin
    o_c = w_imm;
    if (w_alu == AluCountL || w_alu == AluCountT) begin
      o_c = {{(GRLEN-1){1'b0}}, !i_op[OpUnsign]};
    end else if (i_op[OpSa] || w_alu == AluAlign) begin
      o_c = GRLEN'(get_sa(i_inst));
    end else if (w_alu == AluExt || w_alu == AluIns) begin
      o_c = GRLEN'(get_mslsbd(i_inst));
    end
  end

  assign o_br_target = i_pc + o_imm_shifted;

endmodule

// File: rtl/cpu7_ifu_imd_pipe.sv
// Registered D->E boundary for decoded immediates: LANES lane decoders feeding a main register
// with a one-entry skid so in_ready can be a pure register output.
module cpu7_ifu_imd_pipe
  import cpu7_ifu_imd_pipe_pkg::*;
#(
  parameter int unsigned GRLEN = 32,
  parameter int unsigned LANES = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES-1:0]           in_lane_vld,
  input  logic [LANES*32-1:0]        in_inst,
  input  logic [LANES*DecodeResBit-1:0] in_op,
  input  logic [LANES*GRLEN-1:0]     in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES-1:0]           out_lane_vld,
  output logic [LANES*GRLEN-1:0]     out_imm_shifted,
  output logic [LANES*GRLEN-1:0]     out_c,
  output logic [LANES*GRLEN-1:0]     out_br_target
);

  localparam int unsigned DW = LANES * GRLEN;

  logic [DW-1:0]    w_imm, w_c, w_br;
  logic             w_accept, w_consume;
  logic             w_main_valid_d, w_skid_valid_d;
  logic             w_load_main_in, w_load_main_skid, w_load_skid;

  logic             r_main_valid, r_skid_valid, r_in_ready;
  logic [LANES-1:0] r_main_lv, r_skid_lv;
  logic [DW-1:0]    r_main_imm, r_main_c, r_main_br;
  logic [DW-1:0]    r_skid_imm, r_skid_c, r_skid_br;

  for (genvar g = 0; g < LANES; g++) begin : gen_lane
    cpu7_ifu_imd_lane #(
      .GRLEN(GRLEN)
    ) u_lane (
      .i_inst       (in_inst[32*g +: 32]),
      .i_op         (in_op[DecodeResBit*g +: DecodeResBit]),
      .i_pc         (in_pc[GRLEN*g +: GRLEN]),
      .o_imm_shifted(w_imm[GRLEN*g +: GRLEN]),
      .o_c          (w_c[GRLEN*g +: GRLEN]),
      .o_br_target  (w_br[GRLEN*g +: GRLEN])
    );
  end

  assign w_accept  = in_valid & r_in_ready;
  assign w_consume = r_main_valid & out_ready;

  // in_ready is low whenever the skid is full, so accept and a full skid never coincide.
  always_comb begin
    w_main_valid_d   = r_main_valid;
    w_skid_valid_d   = r_skid_valid;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_main_valid_d = 1'b0;
      w_skid_valid_d = 1'b0;
    end else if (r_skid_valid) begin
      if (w_consume) begin
        w_load_main_skid = 1'b1;
        w_skid_valid_d   = 1'b0;
      end
    end else if (w_accept) begin
      if (!r_main_valid || w_consume) begin
        w_load_main_in = 1'b1;
        w_main_valid_d = 1'b1;
      end else begin
        w_load_skid    = 1'b1;
        w_skid_valid_d = 1'b1;
      end
    end else if (w_consume) begin
      w_main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid_d;
      r_skid_valid <= w_skid_valid_d;
      r_in_ready   <= !w_skid_valid_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_main_lv  <= '0;
      r_main_imm <= '0;
      r_main_c   <= '0;
      r_main_br  <= '0;
      r_skid_lv  <= '0;
      r_skid_imm <= '0;
      r_skid_c   <= '0;
      r_skid_br  <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_lv  <= in_lane_vld;
        r_main_imm <= w_imm;
        r_main_c   <= w_c;
        r_main_br  <= w_br;
      end else if (w_load_main_skid) begin
        r_main_lv  <= r_skid_lv;
        r_main_imm <= r_skid_imm;
        r_main_c   <= r_skid_c;
        r_main_br  <= r_skid_br;
      end
      if (w_load_skid) begin
        r_skid_lv  <= in_lane_vld;
        r_skid_imm <= w_imm;
        r_skid_c   <= w_c;
        r_skid_br  <= w_br;
      end
    end
  end

  assign in_ready        = r_in_ready;
  assign out_valid       = r_main_valid;
  assign out_lane_vld    = r_main_lv;
  assign out_imm_shifted = r_main_imm;
  assign out_c           = r_main_c;
  assign out_br_target   = r_main_br;

endmodule
